vregfile: RTL and testbench

Vector register file for the vector unit: 32 architectural registers of VLEN bits each, with three read ports, a dedicated v0 mask port and one write port. The write port applies per-element masking and tail handling for SEW 8/16/32. A busy-bit scoreboard supports issue-time reservation and writeback release. The array has no reset; a 32-cycle zeroing sweep after reset initialises it, which keeps the storage SRAM/latch-array friendly. It sits between vector decode/issue and the vector lanes, alongside the scalar register file.

---
 rtl/vregfile_pkg.sv | 27 ++
 rtl/vregfile_be_gen.sv | 36 +++
 rtl/vregfile.sv | 140 ++++++++++++++
 tb/tb_vregfile.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/vregfile_pkg.sv
// Shared types and constants for the vector register file.
//   sew_e       : encoding of vw_sew_i (element width of a write)
//   vrf_state_e : init-sweep / run states
//   NREG        : number of architectural vector registers
//   vlw()       : width of the active-element-count field for a given VLEN
package vregfile_pkg;

   localparam int unsigned NREG = 32;

   typedef enum logic [1:0] {
      SEW8    = 2'b00,
      SEW16   = 2'b01,
      SEW32   = 2'b10,
      SEW_ILL = 2'b11
   } sew_e;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } vrf_state_e;

   // vl must hold 0..VLEN/8 (max element count at SEW=8) inclusive.
   function automatic int unsigned vlw(input int unsigned vlen);
      return $clog2(vlen / 8) + 1;
   endfunction

endpackage

// File: rtl/vregfile_be_gen.sv
// Byte-enable generator for vector register writes.
// Element i is active when i < vl and (vm or v0[i]); each element's enable is
// replicated over its SEW/8 bytes. Illegal SEW (or SEW above ELEN) writes nothing.
//   sew : element width of the write
//   vl  : active element count (values above VLEN/SEW enable every element)
//   vm  : 1 = unmasked, 0 = gate each element by v0
//   v0  : stored mask register, low VLEN/8 bits (enough for SEW=8)
//   be  : one enable per byte of the register
module vregfile_be_gen
   import vregfile_pkg::*;
#(
   parameter int unsigned VLEN = 128,
   parameter int unsigned ELEN = 32
) (
   input  sew_e                    sew,
   input  logic [vlw(VLEN)-1:0]    vl,
   input  logic                    vm,
   input  logic [VLEN/8-1:0]       v0,
   output logic [VLEN/8-1:0]       be
);

   localparam int unsigned NB  = VLEN / 8;
   localparam int unsigned VLW = vlw(VLEN);

   for (genvar b = 0; b < NB; b++) begin : g_byte
      logic on8, on16, on32;
      // Byte b belongs to element b, b/2 or b/4 depending on SEW.
      assign on8  = (VLW'(b)     < vl) && (vm || v0[b]);
      assign on16 = (VLW'(b / 2) < vl) && (vm || v0[b / 2]);
      assign on32 = (VLW'(b / 4) < vl) && (vm || v0[b / 4]);
      assign be[b] = (sew == SEW8)                  ? on8  :
                     (sew == SEW16 && ELEN >= 16)   ? on16 :
                     (sew == SEW32 && ELEN >= 32)   ? on32 : 1'b0;
   end

endmodule

// File: rtl/vregfile.sv
// Vector register file: 32 x VLEN registers, three read ports, a v0 mask port,
// one masked/tail-aware write port and a busy-bit scoreboard.
// The array has no reset; after rst_n releases, a 32-cycle sweep zeroes it and
// ready_o rises. Reads are combinational with optional write bypass.
//   clk, rst_n             : clock, async active-low reset
//   ready_o                : init sweep complete
//   vs{1,2,3}_addr_i/data_o: read ports
//   vmask_o                : current v0
//   vw_*                   : write port (en, addr, data, sew, vl, vm, last)
//   rsv_en_i/rsv_addr_i    : reservation request; rsv_ok_o accepts it
//   busy_o                 : registered scoreboard busy bits
module vregfile
   import vregfile_pkg::*;
#(
   parameter int unsigned VLEN   = 128,
   parameter int unsigned ELEN   = 32,
   parameter bit          BYPASS = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   output logic                 ready_o,
   input  logic [4:0]           vs1_addr_i,
   input  logic [4:0]           vs2_addr_i,
   input  logic [4:0]           vs3_addr_i,
   output logic [VLEN-1:0]      vs1_data_o,
   output logic [VLEN-1:0]      vs2_data_o,
   output logic [VLEN-1:0]      vs3_data_o,
   output logic [VLEN-1:0]      vmask_o,
   input  logic                 vw_en_i,
   input  logic [4:0]           vw_addr_i,
   input  logic [VLEN-1:0]      vw_data_i,
   input  logic [1:0]           vw_sew_i,
   input  logic [vlw(VLEN)-1:0] vw_vl_i,
   input  logic                 vw_vm_i,
   input  logic                 vw_last_i,
   input  logic                 rsv_en_i,
   input  logic [4:0]           rsv_addr_i,
   output logic                 rsv_ok_o,
   output logic [NREG-1:0]      busy_o
);

   localparam int unsigned NB = VLEN / 8;

   vrf_state_e        state_q, state_d;
   logic [4:0]        idx_q, idx_d;
   logic [NREG-1:0]   busy_q, busy_d;
   logic [VLEN-1:0]   mem_q [NREG];
   logic [NB-1:0]     be;
   logic              ready, wr_act, release_wr;

   assign ready      = (state_q == RUN);
   assign wr_act     = ready && vw_en_i;
   assign release_wr = wr_act && vw_last_i;

   // Mask comes from stored v0 only, so a write to v0 cannot loop through bypass.
   vregfile_be_gen #(
      .VLEN (VLEN),
      .ELEN (ELEN)
   ) u_be_gen (
      .sew (sew_e'(vw_sew_i)),
      .vl  (vw_vl_i),
      .vm  (vw_vm_i),
      .v0  (mem_q[0][NB-1:0]),
      .be  (be)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         INIT: begin
            idx_d = idx_q + 5'd1;
            if (idx_q == 5'(NREG - 1)) state_d = RUN;
         end
         RUN:     state_d = RUN;
         default: state_d = INIT;
      endcase
   end

   always_comb begin
      busy_d   = busy_q;
      rsv_ok_o = ready && rsv_en_i &&
                 (!busy_q[rsv_addr_i] || (release_wr && vw_addr_i == rsv_addr_i));
      // Clear before set: same-register release+reserve leaves the bit set.
      if (release_wr) busy_d[vw_addr_i] = 1'b0;
      if (rsv_ok_o)   busy_d[rsv_addr_i] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= INIT;
         idx_q   <= '0;
         busy_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         busy_q  <= busy_d;
      end
   end

   // Storage is deliberately unreset; the INIT sweep zeroes it.
   always_ff @(posedge clk) begin
      if (!ready) begin
         mem_q[idx_q] <= '0;
      end else if (vw_en_i) begin
         for (int b = 0; b < NB; b++) begin
            if (be[b]) mem_q[vw_addr_i][8*b +: 8] <= vw_data_i[8*b +: 8];
         end
      end
   end

   function automatic logic [VLEN-1:0] merge_bytes(input logic [VLEN-1:0] stored,
                                                   input logic [VLEN-1:0] wdata,
                                                   input logic [NB-1:0]   ben,
                                                   input logic            hit);
      logic [VLEN-1:0] r;
      r = stored;
      if (hit) begin
         for (int b = 0; b < NB; b++) begin
            if (ben[b]) r[8*b +: 8] = wdata[8*b +: 8];
         end
      end
      return r;
   endfunction

   logic hit1, hit2, hit3, hit0;
   assign hit1 = BYPASS && wr_act && (vs1_addr_i == vw_addr_i);
   assign hit2 = BYPASS && wr_act && (vs2_addr_i == vw_addr_i);
   assign hit3 = BYPASS && wr_act && (vs3_addr_i == vw_addr_i);
   assign hit0 = BYPASS && wr_act && (vw_addr_i == 5'd0);

   assign vs1_data_o = ready ? merge_bytes(mem_q[vs1_addr_i], vw_data_i, be, hit1) : '0;
   assign vs2_data_o = ready ? merge_bytes(mem_q[vs2_addr_i], vw_data_i, be, hit2) : '0;
   assign vs3_data_o = ready ? merge_bytes(mem_q[vs3_addr_i], vw_data_i, be, hit3) : '0;
   assign vmask_o    = ready ? merge_bytes(mem_q[0], vw_data_i, be, hit0) : '0;

   assign ready_o = ready;
   assign busy_o  = busy_q;

endmodule

// File: tb/tb_vregfile.sv
// Self-checking bench for vregfile (VLEN=128, ELEN=32, BYPASS=1).
// Table of write/read vectors with hand-computed results, plus hand-written
// sequences for init sweep, scoreboard and mid-run reset.
module tb_vregfile;

   logic         clk, rst_n, ready;
   logic [4:0]   vs1_addr, vs2_addr, vs3_addr;
   logic [127:0] vs1_data, vs2_data, vs3_data, vmask;
   logic         vw_en;
   logic [4:0]   vw_addr;
   logic [127:0] vw_data;
   logic [1:0]   vw_sew;
   logic [4:0]   vw_vl;
   logic         vw_vm, vw_last, rsv_en;
   logic [4:0]   rsv_addr;
   logic         rsv_ok;
   logic [31:0]  busy;

   int checks = 0;
   int errors = 0;

   vregfile #(
      .VLEN   (128),
      .ELEN   (32),
      .BYPASS (1'b1)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ready_o    (ready),
      .vs1_addr_i (vs1_addr),
      .vs2_addr_i (vs2_addr),
      .vs3_addr_i (vs3_addr),
      .vs1_data_o (vs1_data),
      .vs2_data_o (vs2_data),
      .vs3_data_o (vs3_data),
      .vmask_o    (vmask),
      .vw_en_i    (vw_en),
      .vw_addr_i  (vw_addr),
      .vw_data_i  (vw_data),
      .vw_sew_i   (vw_sew),
      .vw_vl_i    (vw_vl),
      .vw_vm_i    (vw_vm),
      .vw_last_i  (vw_last),
      .rsv_en_i   (rsv_en),
      .rsv_addr_i (rsv_addr),
      .rsv_ok_o   (rsv_ok),
      .busy_o     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic         we;
      logic [4:0]   wa;
      logic [127:0] wd;
      logic [1:0]   sew;
      logic [4:0]   vl;
      logic         vm;
      logic [4:0]   ra;
      logic [127:0] exp_rd;
      logic [127:0] exp_mask;
   } vec_t;

   vec_t vecs[14];

   function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [127:0] wd,
                               input logic [1:0] sew, input logic [4:0] vl, input logic vm,
                               input logic [4:0] ra, input logic [127:0] exp_rd,
                               input logic [127:0] exp_mask);
      vec_t v;
      v.we = we; v.wa = wa; v.wd = wd; v.sew = sew; v.vl = vl; v.vm = vm;
      v.ra = ra; v.exp_rd = exp_rd; v.exp_mask = exp_mask;
      return v;
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      vw_en = 1'b0; vw_addr = '0; vw_data = '0; vw_sew = 2'b00; vw_vl = '0;
      vw_vm = 1'b1; vw_last = 1'b0; rsv_en = 1'b0; rsv_addr = '0;
   endtask

   // Runs 32 edges after reset release with a write and a reservation held
   // asserted; both must be ignored while the sweep is in progress.
   task automatic run_sweep(input string tag, input logic [127:0] unused);
      int early;
      early = 0;
      vw_en = 1'b1; vw_addr = 5'd9; vw_data = {16{8'hFF}}; vw_sew = 2'b00;
      vw_vl = 5'd16; vw_vm = 1'b1; rsv_en = 1'b1; rsv_addr = 5'd3; vs1_addr = 5'd4;
      for (int n = 1; n <= 32; n++) begin
         @(posedge clk);
         #1;
         if (n < 32 && ready) early++;
         if (n == 2) begin
            check({tag, "_rsv_ok_init"}, {127'd0, rsv_ok}, 128'd0);
            check({tag, "_rd_init"}, vs1_data, 128'd0);
         end
      end
      idle();
      check({tag, "_ready_early"}, 128'(early), 128'd0);
      check({tag, "_ready_edge32"}, {127'd0, ready}, 128'd1);
      tick();
      check({tag, "_busy_after"}, {96'd0, busy}, 128'd0);
      if (unused != 0) check({tag, "_unused"}, 128'd0, 128'd0);
   endtask

   initial begin
      int nz;
      vecs[0]  = mk(1, 5,  {16{8'hAA}}, 2'b10, 4,  1, 5, {16{8'hAA}}, 128'h0);
      vecs[1]  = mk(1, 5,  {4{32'h11223344}}, 2'b10, 2, 1, 5,
                    128'hAAAAAAAA_AAAAAAAA_11223344_11223344, 128'h0);
      vecs[2]  = mk(0, 0,  128'h0, 2'b00, 0, 1, 5,
                    128'hAAAAAAAA_AAAAAAAA_11223344_11223344, 128'h0);
      vecs[3]  = mk(1, 0,  128'h05, 2'b00, 16, 1, 0, 128'h05, 128'h05);
      vecs[4]  = mk(1, 3,  {16{8'hFF}}, 2'b00, 16, 0, 3, 128'h00FF00FF, 128'h05);
      vecs[5]  = mk(0, 0,  128'h0, 2'b00, 0, 1, 3, 128'h00FF00FF, 128'h05);
      vecs[6]  = mk(1, 6,  {16{8'hFF}}, 2'b01, 3, 1, 6, 128'hFFFF_FFFF_FFFF, 128'h05);
      vecs[7]  = mk(1, 6,  128'h0, 2'b01, 0, 1, 6, 128'hFFFF_FFFF_FFFF, 128'h05);
      vecs[8]  = mk(1, 6,  128'h0, 2'b11, 16, 1, 6, 128'hFFFF_FFFF_FFFF, 128'h05);
      vecs[9]  = mk(1, 8,  {16{8'h5A}}, 2'b00, 20, 1, 8, {16{8'h5A}}, 128'h05);
      vecs[10] = mk(1, 9,  {16{8'h12}}, 2'b01, 8, 0, 9, 128'h1212_0000_1212, 128'h05);
      vecs[11] = mk(1, 10, {16{8'h34}}, 2'b10, 4, 0, 10,
                    128'h00000000_34343434_00000000_34343434, 128'h05);
      vecs[12] = mk(1, 0,  128'h02, 2'b00, 16, 1, 0, 128'h02, 128'h02);
      vecs[13] = mk(1, 11, {16{8'h77}}, 2'b00, 16, 0, 11, 128'h7700, 128'h02);

      idle();
      vs1_addr = '0; vs2_addr = '0; vs3_addr = '0;
      rst_n = 1'b0;
      rsv_en = 1'b1; rsv_addr = 5'd1;
      #12;
      check("rst_ready", {127'd0, ready}, 128'd0);
      check("rst_busy", {96'd0, busy}, 128'd0);
      check("rst_rsv_ok", {127'd0, rsv_ok}, 128'd0);
      check("rst_vs1", vs1_data, 128'd0);
      check("rst_vmask", vmask, 128'd0);
      idle();
      tick();
      rst_n = 1'b1;
      run_sweep("init", 128'd0);

      nz = 0;
      for (int r = 0; r < 32; r++) begin
         vs1_addr = 5'(r); vs2_addr = 5'(r); vs3_addr = 5'(r);
         #1;
         if ((vs1_data | vs2_data | vs3_data) != 128'd0) nz++;
      end
      check("zero_sweep_regs", 128'(nz), 128'd0);
      check("zero_vmask", vmask, 128'd0);

      for (int i = 0; i < 14; i++) begin
         vw_en = vecs[i].we; vw_addr = vecs[i].wa; vw_data = vecs[i].wd;
         vw_sew = vecs[i].sew; vw_vl = vecs[i].vl; vw_vm = vecs[i].vm; vw_last = 1'b0;
         vs1_addr = vecs[i].ra; vs2_addr = vecs[i].ra; vs3_addr = vecs[i].ra;
         #2;
         check($sformatf("vec%0d_vs1", i), vs1_data, vecs[i].exp_rd);
         check($sformatf("vec%0d_vs2", i), vs2_data, vecs[i].exp_rd);
         check($sformatf("vec%0d_vs3", i), vs3_data, vecs[i].exp_rd);
         check($sformatf("vec%0d_vmask", i), vmask, vecs[i].exp_mask);
         tick();
         idle();
         #1;
         check($sformatf("vec%0d_stored", i), vs2_data, vecs[i].exp_rd);
      end
      vs1_addr = 5'd5; vs3_addr = 5'd3;
      #1;
      check("final_v5", vs1_data, 128'hAAAAAAAA_AAAAAAAA_11223344_11223344);
      check("final_v3", vs3_data, 128'h00FF00FF);

      // Scoreboard sequences.
      tick();
      rsv_en = 1'b1; rsv_addr = 5'd7;
      #2 check("rsv7_ok", {127'd0, rsv_ok}, 128'd1);
      tick(); idle();
      check("rsv7_busy", {96'd0, busy}, 128'h80);
      rsv_en = 1'b1; rsv_addr = 5'd7;
      #2 check("rsv7_again_ok", {127'd0, rsv_ok}, 128'd0);
      tick(); idle();
      check("rsv7_again_busy", {96'd0, busy}, 128'h80);
      vw_en = 1'b1; vw_addr = 5'd7; vw_sew = 2'b11; vw_vl = 5'd16; vw_last = 1'b1;
      rsv_en = 1'b1; rsv_addr = 5'd7;
      #2 check("rel_rsv7_ok", {127'd0, rsv_ok}, 128'd1);
      tick(); idle();
      check("rel_rsv7_busy", {96'd0, busy}, 128'h80);

      vw_en = 1'b1; vw_addr = 5'd4; vw_data = {16{8'h3C}}; vw_sew = 2'b00; vw_vl = 5'd16;
      rsv_en = 1'b1; rsv_addr = 5'd4; vs1_addr = 5'd4;
      #2 check("rsv4_ok", {127'd0, rsv_ok}, 128'd1);
      tick(); idle();
      check("rsv4_busy", {96'd0, busy}, 128'h90);
      check("v4_written", vs1_data, {16{8'h3C}});
      vw_en = 1'b1; vw_addr = 5'd4; vw_data = '0; vw_sew = 2'b11; vw_vl = 5'd16;
      vw_last = 1'b1;
      #2 check("sewill_bypass_v4", vs1_data, {16{8'h3C}});
      tick(); idle();
      check("sewill_busy", {96'd0, busy}, 128'h80);
      check("sewill_v4", vs1_data, {16{8'h3C}});
      vw_en = 1'b1; vw_addr = 5'd12; vw_sew = 2'b11; vw_last = 1'b1;
      tick(); idle();
      check("rel_nonbusy", {96'd0, busy}, 128'h80);
      rsv_en = 1'b1; rsv_addr = 5'd4;
      tick(); idle();
      check("rsv4_again_busy", {96'd0, busy}, 128'h90);

      // Mid-run reset.
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", {96'd0, busy}, 128'd0);
      check("mid_rst_ready", {127'd0, ready}, 128'd0);
      check("mid_rst_vs1", vs1_data, 128'd0);
      tick();
      rst_n = 1'b1;
      run_sweep("resweep", 128'd0);
      vs1_addr = 5'd4; vs2_addr = 5'd5; vs3_addr = 5'd0;
      #1;
      check("resweep_v4", vs1_data, 128'd0);
      check("resweep_v5", vs2_data, 128'd0);
      check("resweep_v0", vs3_data, 128'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
